// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between the icache and dcache of one core.
// Data requests win arbitration; an instruction request that has watched
// STARVE_MAX consecutive data completions is forced through on the next one.
// Each granted word costs one IDLE arbitration cycle plus the RAM access.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   // instruction cache side
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   // data cache side
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   // RAM side
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic              ram_ready
);

   // Counter must hold 0..STARVE_MAX; keep at least one bit for a zero limit.
   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_CAP = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      D_ACC = 2'd1,
      I_ACC = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_starve_cnt;
   logic [CNT_W-1:0] w_starve_next;

   logic w_dreq;
   logic w_ireq;
   logic w_starved;
   logic w_d_done;
   logic w_i_done;

   assign w_dreq    = dREN | dWEN;
   assign w_ireq    = iREN;
   assign w_starved = (r_starve_cnt == STARVE_CAP);

   // A completion needs the requester still asking and the RAM finishing.
   // Gating with nRST means a reset arriving mid-access never shows a
   // completion pulse in the cycle it is applied.
   assign w_d_done = (r_state == D_ACC) && w_dreq && ram_ready && nRST;
   assign w_i_done = (r_state == I_ACC) && w_ireq && ram_ready && nRST;

   // State and starvation counter registers.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_next;
         r_starve_cnt <= w_starve_next;
      end
   end

   // Next-state: arbitrate in IDLE, leave an access on completion or abandon.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_dreq && w_ireq && w_starved) begin
               w_state_next = I_ACC;
            end else if (w_dreq) begin
               w_state_next = D_ACC;
            end else if (w_ireq) begin
               w_state_next = I_ACC;
            end else begin
               w_state_next = IDLE;
            end
         end
         D_ACC: begin
            // Dropped request or finished word both return to arbitration.
            if (!w_dreq || ram_ready) begin
               w_state_next = IDLE;
            end
         end
         I_ACC: begin
            if (!w_ireq || ram_ready) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Starvation counter: counts data words granted over a waiting fetch.
   always_comb begin
      w_starve_next = r_starve_cnt;
      if (w_i_done) begin
         w_starve_next = '0;
      end else if (w_d_done) begin
         if (w_ireq) begin
            if (!w_starved) begin
               w_starve_next = r_starve_cnt + CNT_W'(1);
            end
         end else begin
            w_starve_next = '0;
         end
      end
   end

   // RAM strobes and requester responses, combinational from state and inputs.
   always_comb begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (r_state)
         D_ACC: begin
            ramaddr = daddr;
            if (w_dreq) begin
               // A write takes precedence when both strobes are raised.
               if (dWEN) begin
                  ramWEN   = 1'b1;
                  ramstore = dstore;
               end else begin
                  ramREN = 1'b1;
               end
            end
            if (w_d_done) begin
               dwait = 1'b0;
               dload = dWEN ? '0 : ramload;
            end
         end
         I_ACC: begin
            ramaddr = iaddr;
            if (w_ireq) begin
               ramREN = 1'b1;
            end
            if (w_i_done) begin
               iwait = 1'b0;
               iload = ramload;
            end
         end
         default: begin
            // IDLE presents nothing to the RAM and ignores ram_ready.
         end
      endcase
   end

endmodule
